// File: rtl/RV32I_definitions.sv
// Shared RV32I pipeline definitions.
// Holds the hazard-sequencer state encoding and its control bundle.
package RV32I_definitions;

    typedef enum logic [1:0] {
        HZ_RUN,
        HZ_FLUSH,
        HZ_MEM_WAIT,
        HZ_HALT
    } hz_state_t;

    typedef struct packed {
        logic pc_stall;
        logic if_flush;
        logic id_stall;
        logic id_flush;
        logic freeze;
        logic halted;
    } hz_ctrl_t;

    localparam hz_ctrl_t HZ_CTRL_IDLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use comparator: the load in EX writes a register that decode reads.
// Register x0 never creates a hazard.
module load_use_detect #(
    parameter int AW = 5
) (
    input  logic [AW-1:0] i_rs1,
    input  logic [AW-1:0] i_rs2,
    input  logic [AW-1:0] i_rd,
    input  logic          i_mem_rd_en,
    output logic          o_hazard
);

    logic w_rd_nz;
    logic w_match;

    assign w_rd_nz  = |i_rd;
    assign w_match  = (i_rd == i_rs1) | (i_rd == i_rs2);
    assign o_hazard = i_mem_rd_en & w_rd_nz & w_match;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage RV32I pipeline.
// Mealy control outputs; state, flush countdown and perf counters registered.
module pipeline_hazard_ctrl
    import RV32I_definitions::*;
#(
    parameter int REGFILE_ADDR_WIDTH = 5,
    parameter int FLUSH_CYCLES       = 1,
    parameter int CNT_WIDTH          = 32
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic [REGFILE_ADDR_WIDTH-1:0] Dec_Rs1_addr,
    input  logic [REGFILE_ADDR_WIDTH-1:0] Dec_Rs2_addr,
    input  logic [REGFILE_ADDR_WIDTH-1:0] ID_Rd_addr,
    input  logic                          ID_Mem_rd_en,
    input  logic                          ID_Exception,
    input  logic                          EX_Redirect,
    input  logic                          Mem_req,
    input  logic                          Mem_ready,
    input  logic                          Resume,
    input  logic                          Cnt_clr,
    output logic                          PC_Stall,
    output logic                          IF_Flush,
    output logic                          ID_Stall,
    output logic                          ID_Flush,
    output logic                          Freeze,
    output logic                          Halted,
    output logic [CNT_WIDTH-1:0]          Stall_cnt,
    output logic [CNT_WIDTH-1:0]          Flush_cnt
);

    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FW-1:0] FL_RESUME = FW'(FLUSH_CYCLES - 1);
    localparam logic [FW-1:0] FL_REDIR  =
        (FLUSH_CYCLES > 1) ? FW'(FLUSH_CYCLES - 2) : '0;

    hz_state_t r_state;
    hz_state_t r_ret;
    hz_state_t w_state_nxt;
    hz_state_t w_ret_nxt;
    hz_state_t w_base;

    logic [FW-1:0]        r_cnt;
    logic [FW-1:0]        w_cnt_nxt;
    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic [CNT_WIDTH-1:0] r_flush_cnt;

    hz_ctrl_t w_ctrl;
    hz_ctrl_t w_ctrl_g;
    logic     w_frozen;
    logic     w_hazard;
    logic     w_redir_acc;
    logic     w_stall_inc;

    load_use_detect #(
        .AW(REGFILE_ADDR_WIDTH)
    ) u_lud (
        .i_rs1      (Dec_Rs1_addr),
        .i_rs2      (Dec_Rs2_addr),
        .i_rd       (ID_Rd_addr),
        .i_mem_rd_en(ID_Mem_rd_en),
        .o_hazard   (w_hazard)
    );

    assign w_frozen = Mem_req & ~Mem_ready;
    // While waiting on memory, behave as the state we will return to
    assign w_base = (r_state == HZ_MEM_WAIT) ? r_ret : r_state;

    always_comb begin
        w_ctrl      = HZ_CTRL_IDLE;
        w_state_nxt = r_state;
        w_ret_nxt   = r_ret;
        w_cnt_nxt   = r_cnt;
        w_redir_acc = 1'b0;
        if (w_base == HZ_HALT) begin
            w_ctrl.pc_stall = 1'b1;
            w_ctrl.if_flush = 1'b1;
            w_ctrl.id_flush = 1'b1;
            w_ctrl.halted   = 1'b1;
            if (Resume) begin
                w_state_nxt = HZ_FLUSH;
                w_cnt_nxt   = FL_RESUME;
            end
        end else if (w_frozen) begin
            w_ctrl.freeze   = 1'b1;
            w_ctrl.pc_stall = 1'b1;
            w_state_nxt     = HZ_MEM_WAIT;
            w_ret_nxt       = w_base;
        end else if (ID_Exception) begin
            w_ctrl.pc_stall = 1'b1;
            w_ctrl.if_flush = 1'b1;
            w_ctrl.id_flush = 1'b1;
            w_state_nxt     = HZ_HALT;
        end else if (EX_Redirect) begin
            w_ctrl.if_flush = 1'b1;
            w_ctrl.id_flush = 1'b1;
            w_redir_acc     = 1'b1;
            w_cnt_nxt       = FL_REDIR;
            w_state_nxt     = (FLUSH_CYCLES > 1) ? HZ_FLUSH : HZ_RUN;
        end else if (w_base == HZ_FLUSH) begin
            w_ctrl.if_flush = 1'b1;
            w_ctrl.id_flush = 1'b1;
            if (r_cnt == '0) begin
                w_state_nxt = HZ_RUN;
            end else begin
                w_state_nxt = HZ_FLUSH;
                w_cnt_nxt   = r_cnt - FW'(1);
            end
        end else begin
            w_ctrl.id_stall = w_hazard;
            w_ctrl.pc_stall = w_hazard;
            w_state_nxt     = HZ_RUN;
        end
    end

    // Outputs are forced quiet for as long as reset is held
    assign w_ctrl_g    = Reset_n ? w_ctrl : HZ_CTRL_IDLE;
    assign w_stall_inc = w_ctrl_g.id_stall | w_ctrl_g.freeze;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= HZ_RUN;
            r_ret   <= HZ_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ret   <= w_ret_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (Cnt_clr) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_inc) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_redir_acc) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign PC_Stall  = w_ctrl_g.pc_stall;
    assign IF_Flush  = w_ctrl_g.if_flush;
    assign ID_Stall  = w_ctrl_g.id_stall;
    assign ID_Flush  = w_ctrl_g.id_flush;
    assign Freeze    = w_ctrl_g.freeze;
    assign Halted    = w_ctrl_g.halted;
    assign Stall_cnt = r_stall_cnt;
    assign Flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (FLUSH_CYCLES=3, 4-bit counters).
// Control outputs compared as {PC_Stall,IF_Flush,ID_Stall,ID_Flush,Freeze,Halted}.
module tb_pipeline_hazard_ctrl;

    localparam int AW = 5;
    localparam int FC = 3;
    localparam int CW = 4;

    localparam logic [5:0] O_IDLE  = 6'b000000;
    localparam logic [5:0] O_LU    = 6'b101000;
    localparam logic [5:0] O_FLUSH = 6'b010100;
    localparam logic [5:0] O_FRZ   = 6'b100010;
    localparam logic [5:0] O_EXC   = 6'b110100;
    localparam logic [5:0] O_HALT  = 6'b110101;

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic [AW-1:0] Dec_Rs1_addr, Dec_Rs2_addr, ID_Rd_addr;
    logic          ID_Mem_rd_en, ID_Exception, EX_Redirect;
    logic          Mem_req, Mem_ready, Resume, Cnt_clr;
    logic          PC_Stall, IF_Flush, ID_Stall, ID_Flush, Freeze, Halted;
    logic [CW-1:0] Stall_cnt, Flush_cnt;
    logic [5:0]    w_out;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 Clk = ~Clk;

    pipeline_hazard_ctrl #(
        .REGFILE_ADDR_WIDTH(AW),
        .FLUSH_CYCLES      (FC),
        .CNT_WIDTH         (CW)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .Dec_Rs1_addr(Dec_Rs1_addr),
        .Dec_Rs2_addr(Dec_Rs2_addr),
        .ID_Rd_addr  (ID_Rd_addr),
        .ID_Mem_rd_en(ID_Mem_rd_en),
        .ID_Exception(ID_Exception),
        .EX_Redirect (EX_Redirect),
        .Mem_req     (Mem_req),
        .Mem_ready   (Mem_ready),
        .Resume      (Resume),
        .Cnt_clr     (Cnt_clr),
        .PC_Stall    (PC_Stall),
        .IF_Flush    (IF_Flush),
        .ID_Stall    (ID_Stall),
        .ID_Flush    (ID_Flush),
        .Freeze      (Freeze),
        .Halted      (Halted),
        .Stall_cnt   (Stall_cnt),
        .Flush_cnt   (Flush_cnt)
    );

    assign w_out = {PC_Stall, IF_Flush, ID_Stall, ID_Flush, Freeze, Halted};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        Dec_Rs1_addr = '0;
        Dec_Rs2_addr = '0;
        ID_Rd_addr   = '0;
        ID_Mem_rd_en = 1'b0;
        ID_Exception = 1'b0;
        EX_Redirect  = 1'b0;
        Mem_req      = 1'b0;
        Mem_ready    = 1'b0;
        Resume       = 1'b0;
        Cnt_clr      = 1'b0;
    endtask

    initial begin
        Reset_n = 1'b0;
        idle();
        #12;
        chk("rst_out", 32'(w_out), 32'(O_IDLE));
        chk("rst_scnt", 32'(Stall_cnt), 0);
        ID_Mem_rd_en = 1'b1;
        ID_Rd_addr   = 5;
        Dec_Rs2_addr = 5;
        #1;
        chk("rst_gate", 32'(w_out), 32'(O_IDLE));
        idle();
        tick();
        Reset_n = 1'b1;
        tick();
        chk("run_idle", 32'(w_out), 32'(O_IDLE));
        chk("run_fcnt", 32'(Flush_cnt), 0);

        // load-use on rs2
        ID_Mem_rd_en = 1'b1;
        ID_Rd_addr   = 5;
        Dec_Rs2_addr = 5;
        #1;
        chk("lu_rs2", 32'(w_out), 32'(O_LU));
        tick();
        idle();
        #1;
        chk("lu_done", 32'(w_out), 32'(O_IDLE));
        chk("lu_scnt", 32'(Stall_cnt), 1);

        // x0 load never hazards
        ID_Mem_rd_en = 1'b1;
        #1;
        chk("lu_x0", 32'(w_out), 32'(O_IDLE));
        // match without a load is harmless
        ID_Mem_rd_en = 1'b0;
        ID_Rd_addr   = 7;
        Dec_Rs1_addr = 7;
        #1;
        chk("lu_noload", 32'(w_out), 32'(O_IDLE));
        ID_Mem_rd_en = 1'b1;
        #1;
        chk("lu_rs1", 32'(w_out), 32'(O_LU));
        tick();
        idle();
        chk("lu_scnt2", 32'(Stall_cnt), 2);

        // redirect: three flush cycles, PC not stalled
        EX_Redirect = 1'b1;
        #1;
        chk("rd_c0", 32'(w_out), 32'(O_FLUSH));
        tick();
        idle();
        chk("rd_c1", 32'(w_out), 32'(O_FLUSH));
        chk("rd_fcnt", 32'(Flush_cnt), 1);
        tick();
        chk("rd_c2", 32'(w_out), 32'(O_FLUSH));
        tick();
        chk("rd_end", 32'(w_out), 32'(O_IDLE));

        // memory wait masks a held redirect
        Mem_req     = 1'b1;
        EX_Redirect = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("mw_frz%0d", i), 32'(w_out), 32'(O_FRZ));
            tick();
        end
        Mem_ready = 1'b1;
        #1;
        chk("mw_ready", 32'(w_out), 32'(O_FLUSH));
        chk("mw_scnt", 32'(Stall_cnt), 6);
        chk("mw_fcnt0", 32'(Flush_cnt), 1);
        tick();
        idle();
        chk("mw_fl1", 32'(w_out), 32'(O_FLUSH));
        chk("mw_fcnt1", 32'(Flush_cnt), 2);
        tick();
        chk("mw_fl2", 32'(w_out), 32'(O_FLUSH));
        tick();
        chk("mw_end", 32'(w_out), 32'(O_IDLE));

        // Resume outside HALT is ignored
        Resume = 1'b1;
        #1;
        chk("res_run", 32'(w_out), 32'(O_IDLE));
        tick();
        idle();
        chk("res_run2", 32'(w_out), 32'(O_IDLE));

        // exception parks the core
        ID_Exception = 1'b1;
        #1;
        chk("exc", 32'(w_out), 32'(O_EXC));
        tick();
        idle();
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("halt%0d", i), 32'(w_out), 32'(O_HALT));
            tick();
        end
        Resume = 1'b1;
        #1;
        chk("halt_res", 32'(w_out), 32'(O_HALT));
        tick();
        idle();
        for (int i = 0; i < FC; i++) begin
            chk($sformatf("res_fl%0d", i), 32'(w_out), 32'(O_FLUSH));
            tick();
        end
        chk("res_end", 32'(w_out), 32'(O_IDLE));
        chk("res_scnt", 32'(Stall_cnt), 6);

        // clear wins over a same-cycle freeze
        Cnt_clr = 1'b1;
        Mem_req = 1'b1;
        #1;
        chk("clr_frz", 32'(w_out), 32'(O_FRZ));
        tick();
        Cnt_clr = 1'b0;
        chk("clr_scnt", 32'(Stall_cnt), 0);
        chk("clr_fcnt", 32'(Flush_cnt), 0);
        repeat (15) tick();
        chk("wrap_max", 32'(Stall_cnt), 15);
        tick();
        chk("wrap_zero", 32'(Stall_cnt), 0);
        Mem_ready = 1'b1;
        tick();
        idle();
        chk("wrap_run", 32'(w_out), 32'(O_IDLE));

        // asynchronous reset in the middle of a flush
        EX_Redirect = 1'b1;
        tick();
        idle();
        chk("mid_fl", 32'(w_out), 32'(O_FLUSH));
        chk("mid_fcnt", 32'(Flush_cnt), 1);
        Reset_n = 1'b0;
        #1;
        chk("mid_rst", 32'(w_out), 32'(O_IDLE));
        chk("mid_rfcnt", 32'(Flush_cnt), 0);
        chk("mid_rscnt", 32'(Stall_cnt), 0);
        tick();
        Reset_n = 1'b1;
        tick();
        chk("post_rst", 32'(w_out), 32'(O_IDLE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
